// File: rtl/vga_pixel_out.sv
// VGA pin stage: aligns sync/blank with renderer latency, blanks and 2x2-dithers 4-bit colour to 2 bits.
// Define VGA_TEMPORAL_DITHER_EN to rotate the dither threshold with frame_count[1:0].
module vga_pixel_out #(
  parameter int LATENCY     = 2,
  parameter bit SYNC_INVERT = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_in,
  input  logic       x_lsb,
  input  logic       y_lsb,
  input  logic       vsync_pulse,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [1:0] r_out,
  output logic [1:0] g_out,
  output logic [1:0] b_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] frame_count
);

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic x;
    logic y;
  } tm_t;

  localparam tm_t TM_IDLE = '{
    hs: 1'b0, vs: 1'b0, blank: 1'b1,
    x: 1'b0, y: 1'b0
  };

  tm_t        tm_in;
  tm_t        tm_dly;
  tm_t        tm_q [LATENCY];
  logic [1:0] thr;
  logic [1:0] thr_eff;
  logic [1:0] r_d, g_d, b_d;
  logic [1:0] r_q, g_q, b_q;
  logic       hs_d, vs_d;
  logic       hs_q, vs_q;
  logic [7:0] fc_d, fc_q;

  assign tm_in = '{
    hs: hsync_in, vs: vsync_in, blank: blank_in,
    x: x_lsb, y: y_lsb
  };

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++)
        tm_q[i] <= TM_IDLE;
    end else begin
      tm_q[0] <= tm_in;
      for (int i = 1; i < LATENCY; i++)
        tm_q[i] <= tm_q[i-1];
    end
  end

  assign tm_dly = tm_q[LATENCY-1];

  // Bayer 2x2: B(0,0)=0 B(1,0)=2 B(0,1)=3 B(1,1)=1
  always_comb begin
    thr = 2'd0;
    unique case ({tm_dly.y, tm_dly.x})
      2'b00:   thr = 2'd0;
      2'b01:   thr = 2'd2;
      2'b10:   thr = 2'd3;
      default: thr = 2'd1;
    endcase
  end

`ifdef VGA_TEMPORAL_DITHER_EN
  assign thr_eff = thr + fc_q[1:0];
`else
  assign thr_eff = thr;
`endif

  function automatic logic [1:0] dith(
    input logic [3:0] c,
    input logic [1:0] t
  );
    if (c[3:2] == 2'd3)
      return 2'd3;
    return c[3:2] + {1'b0, (c[1:0] > t)};
  endfunction

  always_comb begin
    r_d  = 2'd0;
    g_d  = 2'd0;
    b_d  = 2'd0;
    hs_d = tm_dly.hs ^ SYNC_INVERT;
    vs_d = tm_dly.vs ^ SYNC_INVERT;
    fc_d = fc_q + {7'd0, vsync_pulse};
    if (!tm_dly.blank) begin
      r_d = dith(r_in, thr_eff);
      g_d = dith(g_in, thr_eff);
      b_d = dith(b_in, thr_eff);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q  <= 2'd0;
      g_q  <= 2'd0;
      b_q  <= 2'd0;
      hs_q <= SYNC_INVERT;
      vs_q <= SYNC_INVERT;
      fc_q <= 8'd0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fc_q <= fc_d;
    end
  end

  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Bench for vga_pixel_out: LATENCY=3, SYNC_INVERT=1, table vectors
// plus reset, latency, frame counter and optional temporal sequences.
module tb_vga_pixel_out;

  localparam int L = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hsync_in, vsync_in, blank_in;
  logic       x_lsb, y_lsb, vsync_pulse;
  logic [3:0] r_in, g_in, b_in;
  logic [1:0] r_out, g_out, b_out;
  logic       hsync_out, vsync_out;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  vga_pixel_out #(
    .LATENCY(L),
    .SYNC_INVERT(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .blank_in(blank_in),
    .x_lsb(x_lsb),
    .y_lsb(y_lsb),
    .vsync_pulse(vsync_pulse),
    .r_in(r_in),
    .g_in(g_in),
    .b_in(b_in),
    .r_out(r_out),
    .g_out(g_out),
    .b_out(b_out),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
  } exp_t;

  typedef struct {
    logic       hs, vs, bl, x, y;
    logic [3:0] r, g, b;
    exp_t       e;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];
  vec_t tbl[12];

  function automatic exp_t mke(int r, int g, int b, int hs, int vs);
    exp_t e;
    e.r  = 2'(r);
    e.g  = 2'(g);
    e.b  = 2'(b);
    e.hs = 1'(hs);
    e.vs = 1'(vs);
    return e;
  endfunction

  function automatic vec_t mk(int hs, int vs, int bl, int x, int y,
                              int r, int g, int b, exp_t e);
    vec_t v;
    v.hs = 1'(hs);
    v.vs = 1'(vs);
    v.bl = 1'(bl);
    v.x  = 1'(x);
    v.y  = 1'(y);
    v.r  = 4'(r);
    v.g  = 4'(g);
    v.b  = 4'(b);
    v.e  = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic hs, input logic vs, input logic bl,
                     input logic x, input logic y, input logic [3:0] r,
                     input logic [3:0] g, input logic [3:0] b,
                     input logic vp);
    hsync_in    = hs;
    vsync_in    = vs;
    blank_in    = bl;
    x_lsb       = x;
    y_lsb       = y;
    r_in        = r;
    g_in        = g;
    b_in        = b;
    vsync_pulse = vp;
  endtask

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s got=empty want=entry", nm);
    end else begin
      e = sbq.pop_front();
      chk8(nm, {r_out, g_out, b_out, hsync_out, vsync_out}, e);
    end
  endtask

  task automatic hold_vec(input vec_t v, input string nm);
    drv(v.hs, v.vs, v.bl, v.x, v.y, v.r, v.g, v.b, 1'b0);
    sbq.push_back(v.e);
    repeat (L + 1) tick();
    pop_chk(nm);
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 6, 14, 0, mke(2, 3, 0, 1, 1));
    tbl[1]  = mk(0, 0, 0, 1, 0, 6, 14, 0, mke(1, 3, 0, 1, 1));
    tbl[2]  = mk(0, 0, 0, 0, 1, 6, 14, 0, mke(1, 3, 0, 1, 1));
    tbl[3]  = mk(0, 0, 0, 1, 1, 6, 14, 0, mke(2, 3, 0, 1, 1));
    tbl[4]  = mk(0, 0, 0, 0, 1, 11, 9, 15, mke(2, 2, 3, 1, 1));
    tbl[5]  = mk(0, 0, 0, 1, 1, 11, 9, 12, mke(3, 2, 3, 1, 1));
    tbl[6]  = mk(0, 0, 0, 1, 0, 3, 2, 1, mke(1, 0, 0, 1, 1));
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 4, 13, mke(1, 1, 3, 1, 1));
    tbl[8]  = mk(1, 1, 1, 0, 0, 15, 15, 15, mke(0, 0, 0, 0, 0));
    tbl[9]  = mk(0, 1, 1, 1, 1, 15, 15, 15, mke(0, 0, 0, 1, 0));
    tbl[10] = mk(1, 0, 0, 0, 0, 15, 0, 15, mke(3, 0, 3, 0, 1));
    tbl[11] = mk(0, 0, 0, 1, 0, 15, 15, 0, mke(3, 3, 0, 1, 1));

    // reset held with random activity on every input
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
          1'($urandom));
      tick();
    end
    chk8("rst_rgb", {2'b0, r_out, g_out, b_out}, 8'h00);
    chk8("rst_sync", {6'b0, hsync_out, vsync_out}, 8'h03);
    chk8("rst_fc", frame_count, 8'h00);

    // first real sample after release: pins at LATENCY+1
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    reset_n = 1'b1;
    for (int k = 1; k <= L + 2; k++) begin
      sbq.push_back(mke(k >= L + 1 ? 3 : 0, 0, 0,
                        k == L + 1 ? 0 : 1, 1));
      tick();
      pop_chk($sformatf("refill_%0d", k));
      drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    end

    // hsync pulse at 10, colour F at 13 -> both at pins after cycle 13
    for (int c = 0; c < 20; c++) begin
      drv(c == 10, 1'b0, 1'b0, 1'b0, 1'b0,
          c == 13 ? 4'hF : 4'h0, 4'h0, 4'h0, 1'b0);
      sbq.push_back(mke(c == 13 ? 3 : 0, 0, 0, c == 13 ? 0 : 1, 1));
      tick();
      pop_chk($sformatf("lat_c%0d", c));
    end

    for (int i = 0; i < 12; i++)
      hold_vec(tbl[i], $sformatf("vec%0d", i));

    // mid-frame reset, then refill without stale samples
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b1);
    repeat (L + 1) tick();
    reset_n = 1'b0;
    #2;
    chk8("midrst_pins", {r_out, g_out, b_out, hsync_out, vsync_out},
         8'h03);
    chk8("midrst_fc", frame_count, 8'h00);
    tick();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0);
    reset_n = 1'b1;
    for (int k = 1; k <= L + 1; k++) begin
      sbq.push_back(k == L + 1 ? mke(3, 3, 3, 1, 1) : mke(0, 0, 0, 1, 1));
      tick();
      pop_chk($sformatf("midrefill_%0d", k));
    end

    // frame counter: single, double-width, then wrap
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    tick();
    vsync_pulse = 1'b0;
    tick();
    chk8("fc_one", frame_count, 8'd1);
    vsync_pulse = 1'b1;
    tick();
    tick();
    vsync_pulse = 1'b0;
    tick();
    chk8("fc_wide", frame_count, 8'd3);
    for (int i = 0; i < 253; i++) begin
      vsync_pulse = 1'b1;
      tick();
      vsync_pulse = 1'b0;
      tick();
      if (i == 251)
        chk8("fc_255", frame_count, 8'd255);
    end
    chk8("fc_wrap", frame_count, 8'd0);

`ifdef VGA_TEMPORAL_DITHER_EN
    begin
      logic [1:0] tr [4];
      tr[0] = 2'd2;
      tr[1] = 2'd1;
      tr[2] = 2'd1;
      tr[3] = 2'd1;
      for (int f = 0; f < 4; f++) begin
        hold_vec(mk(0, 0, 0, 0, 0, 5, 0, 0, mke(tr[f], 0, 0, 1, 1)),
                 $sformatf("temporal_f%0d", f));
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
      end
    end
`endif

    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_out.md
Name: vga_pixel_out

Overview:
- Output stage directly downstream of the VGA timing generator.
- Takes that generator's sync, blank, position LSBs and frame pulse, plus 4-bit-per-channel colour from the renderer.
- Drives 2-bit-per-channel RGB and sync to the pins: applies blanking, aligns sync with the renderer's latency, and does 2x2 ordered dither with an 8-bit frame counter.

Parameters:
- LATENCY, 2, renderer latency in clocks from x/y presented to colour valid; legal range 1..8.
- SYNC_INVERT, 0, 1 inverts hsync_out/vsync_out (active-low sync at the pins).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- hsync_in  in  1  hsync from timing generator, active high.
- vsync_in  in  1  vsync from timing generator, active high.
- blank_in  in  1  1 = outside visible area.
- x_lsb  in  1  x_pos[0] of the current pixel.
- y_lsb  in  1  y_pos[0] of the current pixel.
- vsync_pulse  in  1  single-cycle frame strobe.
- r_in, g_in, b_in  in  4 each  renderer colour; valid LATENCY clocks after the matching x/y.
- r_out, g_out, b_out  out  2 each  registered dithered colour.
- hsync_out, vsync_out  out  1 each  registered sync, polarity per SYNC_INVERT.
- frame_count  out  8  frames since reset.

Behaviour:
- Reset is asynchronous, asserted on reset_n low:
  - all pipeline stages take the inactive state: sync 0, blank 1, lsbs 0;
  - r/g/b_out = 0;
  - hsync_out = vsync_out = SYNC_INVERT;
  - frame_count = 0.
- Alignment pipeline:
  - hsync_in, vsync_in, blank_in, x_lsb and y_lsb pass through a LATENCY-stage shift register, one stage per clock, no enable.
  - The stage-LATENCY values are combined with r/g/b_in and registered once into the outputs.
  - Total latency from timing inputs to pins is LATENCY+1 clocks; colour-to-pin latency is 1 clock.
- Dither threshold:
  - t = B(x,y) from x = delayed x_lsb, y = delayed y_lsb: B(0,0)=0, B(1,0)=2, B(0,1)=3, B(1,1)=1.
  - The effective threshold is t' = t (temporal dither is covered under Optional Feature).
- Per channel, with 4-bit c:
  - q = c[3:2], f = c[1:0];
  - out = q + (f > t') when q < 3, else out = 3 (saturate; no wrap).
  - c = 4'hF always gives 3; c = 4'h0 always gives 0.
- Blanking: when the delayed blank is 1, r/g/b_out are registered as 0 regardless of r/g/b_in.
- Sync: hsync_out = delayed hsync XOR SYNC_INVERT; vsync_out likewise. Blank does not gate sync.
- frame_count:
  - increments by 1 on each clock where vsync_pulse = 1, using the undelayed input;
  - wraps 255 -> 0;
  - vsync_pulse held high for N cycles counts N.
- Reset mid-frame: outputs return to reset values immediately. After release, the pipeline refills with real inputs over LATENCY+1 clocks, and no stale pre-reset sample appears at the pins.

Optional Feature:
- Macro: VGA_TEMPORAL_DITHER_EN.
- Defined: t' = (t + frame_count[1:0]) mod 4, so the dither pattern rotates each frame. The value used is frame_count as registered at the output clock edge.
- Undefined: t' = t; frame_count still counts.

Test Plan:
- Reset: hold reset_n=0 with random inputs, SYNC_INVERT=1 -> rgb_out=0, hsync_out=vsync_out=1, frame_count=0; after release, the first real sample appears exactly LATENCY+1 clocks after presentation.
- Latency: LATENCY=3, hsync_in single-cycle pulse at cycle 10 -> hsync_out high only at cycle 14; colour 4'hF on r_in at cycle 13 with blank low -> r_out=3 at cycle 14.
- Dither: r_in=4'h6 (q=1, f=2), blank low, (x,y) swept (0,0),(1,0),(0,1),(1,1) -> r_out = 2,1,1,2. g_in=4'hE -> 3 at every position. b_in=4'h0 -> 0 everywhere.
- Blanking: blank_in=1 with r/g/b_in=4'hF -> all outputs 0 while the delayed blank is high; sync still passes.
- Frame counter: 256 vsync_pulse strobes -> frame_count wraps to 0. A 2-cycle-wide pulse -> +2.
- Temporal (macro defined): r_in=4'h5, (x,y)=(0,0), frames 0..3 -> t'=0,1,2,3 -> r_out = 2,1,1,1.
